esfa_cell_sequencer: RTL and testbench

- Command sequencer for the ESFA associative memory-cell array.
- Accepts one high-level command at a time from a single requester over a valid/ready handshake.
- Broadcasts the selector, index, value and metadata sequence to all `NUM_CELLS` memory cells, collects their per-cell hit flags and results, and returns a single priority-resolved response.
- Sits between the top-level ESFA request logic and the replicated cell array.

---
 rtl/esfa_cell_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_esfa_cell_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/esfa_cell_sequencer.sv
// esfa_cell_sequencer: runs one ESFA command at a time against the cell
// array. It broadcasts the selector, index, value and metadata, then turns
// the per-cell hit flags into one response where the lowest index wins.
//
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   cmd_valid/ready, cmd_*   command handshake and operands
//   rsp_valid/ready, rsp_*   response handshake and result
//   cell_selector, cell_inserted_index, cell_inserted_value,
//   cell_metadata, cell_isMetadata      registered broadcast to all cells
//   cell_bool, cell_result_value, cell_context   per-cell returns
//
// Build option: define ESFA_SEQ_MULTIHIT_EN to enable rsp_multi.
// Without it, rsp_multi is tied to 0.

module esfa_cell_sequencer #(
    parameter int NUM_CELLS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [7:0]             cmd_array,
    input  logic [7:0]             cmd_index,
    input  logic [7:0]             cmd_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_hit,
    output logic [7:0]             rsp_value,
    output logic [7:0]             rsp_context,
    output logic [7:0]             rsp_cell,
    output logic                   rsp_multi,
    output logic [7:0]             cell_selector,
    output logic [7:0]             cell_inserted_index,
    output logic [7:0]             cell_inserted_value,
    output logic [7:0]             cell_metadata,
    output logic                   cell_isMetadata,
    input  logic [NUM_CELLS-1:0]   cell_bool,
    input  logic [NUM_CELLS*8-1:0] cell_result_value,
    input  logic [NUM_CELLS*8-1:0] cell_context
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [2:0] OP_INSERT = 3'd0;

    localparam logic [7:0] SEL_NOP    = 8'd8;
    localparam logic [7:0] SEL_WRITE  = 8'd0;
    localparam logic [7:0] SEL_INSERT = 8'd5;
    localparam logic [7:0] SEL_LOOKUP = 8'd1;
    localparam logic [7:0] SEL_ENCODE = 8'd2;
    localparam logic [7:0] SEL_ENRANK = 8'd6;

    logic [2:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] win_q, win_d;
    logic       wr_ph_q, wr_ph_d;
    logic [7:0] sel_q, sel_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] val_q, val_d;
    logic [7:0] meta_q, meta_d;
    logic       ismeta_q, ismeta_d;
    logic       rsp_hit_q, rsp_hit_d;
    logic [7:0] rsp_value_q, rsp_value_d;
    logic [7:0] rsp_context_q, rsp_context_d;
    logic [7:0] rsp_cell_q, rsp_cell_d;

    logic       hit_any;
    logic [7:0] hit_idx;
    logic [7:0] hit_val;
    logic [7:0] hit_ctx;

    // Walk from the top down so the lowest set index is the last to be
    // written and therefore wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 8'd0;
        hit_val = 8'd0;
        hit_ctx = 8'd0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (cell_bool[i]) begin
                hit_any = 1'b1;
                hit_idx = 8'(i);
                hit_val = cell_result_value[i*8 +: 8];
                hit_ctx = cell_context[i*8 +: 8];
            end
        end
    end

`ifdef ESFA_SEQ_MULTIHIT_EN
    logic rsp_multi_q, rsp_multi_d;
    logic hit_multi;
    logic seen;

    // Flags a second set bit; no full population count is needed.
    always_comb begin
        hit_multi = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_bool[i]) begin
                if (seen) hit_multi = 1'b1;
                seen = 1'b1;
            end
        end
    end

    assign rsp_multi = rsp_multi_q;
`else
    assign rsp_multi = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        win_d         = win_q;
        wr_ph_d       = wr_ph_q;
        sel_d         = SEL_NOP;
        idx_d         = idx_q;
        val_d         = val_q;
        meta_d        = meta_q;
        ismeta_d      = ismeta_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_value_d   = rsp_value_q;
        rsp_context_d = rsp_context_q;
        rsp_cell_d    = rsp_cell_q;
`ifdef ESFA_SEQ_MULTIHIT_EN
        rsp_multi_d   = rsp_multi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d          = cmd_op;
                    rsp_hit_d     = 1'b0;
                    rsp_value_d   = 8'd0;
                    rsp_context_d = 8'd0;
                    rsp_cell_d    = 8'd0;
`ifdef ESFA_SEQ_MULTIHIT_EN
                    rsp_multi_d   = 1'b0;
`endif
                    if (cmd_op[2]) begin
                        // Reserved op: answer at once with an empty result.
                        state_d = S_RESP;
                    end else begin
                        state_d  = S_ISSUE;
                        ismeta_d = 1'b1;
                        idx_d    = cmd_index;
                        val_d    = cmd_value;
                        meta_d   = (cmd_op == OP_INSERT) ? 8'd0 : cmd_array;
                        unique case (cmd_op[1:0])
                            2'd0: sel_d = SEL_INSERT;
                            2'd1: sel_d = SEL_LOOKUP;
                            2'd2: sel_d = SEL_ENCODE;
                            2'd3: sel_d = SEL_ENRANK;
                        endcase
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (op_q == OP_INSERT) begin
                    if (hit_any) begin
                        sel_d   = SEL_WRITE;
                        meta_d  = hit_idx;
                        win_d   = hit_idx;
                        wr_ph_d = 1'b0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    rsp_hit_d     = hit_any;
                    rsp_cell_d    = hit_idx;
                    rsp_value_d   = hit_val;
                    rsp_context_d = hit_ctx;
`ifdef ESFA_SEQ_MULTIHIT_EN
                    rsp_multi_d   = hit_multi;
`endif
                    state_d       = S_RESP;
                end
            end
            S_WRITE: begin
                // First cycle lets the cell capture selector 0; the
                // second one closes out with the response.
                if (!wr_ph_q) begin
                    wr_ph_d = 1'b1;
                end else begin
                    rsp_hit_d     = 1'b1;
                    rsp_cell_d    = win_q;
                    rsp_value_d   = win_q;
                    rsp_context_d = win_q;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            win_q         <= 8'd0;
            wr_ph_q       <= 1'b0;
            sel_q         <= SEL_NOP;
            idx_q         <= 8'd0;
            val_q         <= 8'd0;
            meta_q        <= 8'd0;
            ismeta_q      <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_value_q   <= 8'd0;
            rsp_context_q <= 8'd0;
            rsp_cell_q    <= 8'd0;
`ifdef ESFA_SEQ_MULTIHIT_EN
            rsp_multi_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            win_q         <= win_d;
            wr_ph_q       <= wr_ph_d;
            sel_q         <= sel_d;
            idx_q         <= idx_d;
            val_q         <= val_d;
            meta_q        <= meta_d;
            ismeta_q      <= ismeta_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_value_q   <= rsp_value_d;
            rsp_context_q <= rsp_context_d;
            rsp_cell_q    <= rsp_cell_d;
`ifdef ESFA_SEQ_MULTIHIT_EN
            rsp_multi_q   <= rsp_multi_d;
`endif
        end
    end

    assign cmd_ready           = (state_q == S_IDLE);
    assign rsp_valid           = (state_q == S_RESP);
    assign rsp_hit             = rsp_hit_q;
    assign rsp_value           = rsp_value_q;
    assign rsp_context         = rsp_context_q;
    assign rsp_cell            = rsp_cell_q;
    assign cell_selector       = sel_q;
    assign cell_inserted_index = idx_q;
    assign cell_inserted_value = val_q;
    assign cell_metadata       = meta_q;
    assign cell_isMetadata     = ismeta_q;

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// tb_esfa_cell_sequencer: directed plus random commands checked against
// a reference model of the sequencer's response rules.

module tb_esfa_cell_sequencer;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [7:0]     cmd_array;
    logic [7:0]     cmd_index;
    logic [7:0]     cmd_value;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_hit;
    logic [7:0]     rsp_value;
    logic [7:0]     rsp_context;
    logic [7:0]     rsp_cell;
    logic           rsp_multi;
    logic [7:0]     cell_selector;
    logic [7:0]     cell_inserted_index;
    logic [7:0]     cell_inserted_value;
    logic [7:0]     cell_metadata;
    logic           cell_isMetadata;
    logic [N-1:0]   cell_bool;
    logic [N*8-1:0] cell_result_value;
    logic [N*8-1:0] cell_context;

    int total = 0;
    int bad   = 0;

    esfa_cell_sequencer #(.NUM_CELLS(N)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_op              (cmd_op),
        .cmd_array           (cmd_array),
        .cmd_index           (cmd_index),
        .cmd_value           (cmd_value),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_hit             (rsp_hit),
        .rsp_value           (rsp_value),
        .rsp_context         (rsp_context),
        .rsp_cell            (rsp_cell),
        .rsp_multi           (rsp_multi),
        .cell_selector       (cell_selector),
        .cell_inserted_index (cell_inserted_index),
        .cell_inserted_value (cell_inserted_value),
        .cell_metadata       (cell_metadata),
        .cell_isMetadata     (cell_isMetadata),
        .cell_bool           (cell_bool),
        .cell_result_value   (cell_result_value),
        .cell_context        (cell_context)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] op_sel(input logic [2:0] op);
        case (op)
            3'd0:    return 8'd5;
            3'd1:    return 8'd1;
            3'd2:    return 8'd2;
            3'd3:    return 8'd6;
            default: return 8'd8;
        endcase
    endfunction

    // Issue one command, follow the broadcast, check the response, then
    // hold it for 'stall' cycles (with an ignored command) and release.
    task automatic run_cmd(input string nm, input logic [2:0] op,
                           input logic [7:0] arr, input logic [7:0] idx,
                           input logic [7:0] val, input logic [N-1:0] b,
                           input logic [N*8-1:0] rv, input logic [N*8-1:0] cx,
                           input int stall);
        int   first;
        int   lat;
        int   t;
        logic eh, em;
        logic [7:0] ec, ev, ex, es;
        logic [7:0] h_val;
        first = -1;
        for (int i = 0; i < N; i++)
            if (b[i] && first < 0) first = i;
        eh = 1'b0; em = 1'b0;
        ec = 8'd0; ev = 8'd0; ex = 8'd0;
        if (op > 3'd3) begin
            lat = 0;
        end else if (op == 3'd0) begin
            lat = (first >= 0) ? 4 : 2;
            if (first >= 0) begin
                eh = 1'b1;
                ec = 8'(first); ev = 8'(first); ex = 8'(first);
            end
        end else begin
            lat = 2;
            if (first >= 0) begin
                eh = 1'b1;
                ec = 8'(first);
                ev = rv[first*8 +: 8];
                ex = cx[first*8 +: 8];
`ifdef ESFA_SEQ_MULTIHIT_EN
                em = ($countones(b) > 1);
`endif
            end
        end

        cell_bool = b;
        cell_result_value = rv;
        cell_context = cx;
        cmd_op = op; cmd_array = arr; cmd_index = idx; cmd_value = val;
        rsp_ready = 1'b0;
        chk({nm, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 12) begin
            if (t == 0) es = op_sel(op);
            else if (t == 2 && op == 3'd0) es = 8'd0;
            else es = 8'd8;
            chk({nm, ".sel"}, 32'(cell_selector), 32'(es));
            chk({nm, ".rdy_low"}, 32'(cmd_ready), 32'd0);
            if (t == 0) begin
                chk({nm, ".meta"}, 32'(cell_metadata), (op == 3'd0) ? 32'd0 : 32'(arr));
                chk({nm, ".ismeta"}, 32'(cell_isMetadata), 32'd1);
                chk({nm, ".idx"}, 32'(cell_inserted_index), 32'(idx));
                chk({nm, ".val"}, 32'(cell_inserted_value), 32'(val));
            end
            if (t == 2 && op == 3'd0)
                chk({nm, ".wmeta"}, 32'(cell_metadata), 32'(first));
            tick();
            t++;
        end
        chk({nm, ".latency"}, 32'(t), 32'(lat));
        chk({nm, ".hit"}, 32'(rsp_hit), 32'(eh));
        chk({nm, ".cell"}, 32'(rsp_cell), 32'(ec));
        chk({nm, ".value"}, 32'(rsp_value), 32'(ev));
        chk({nm, ".ctx"}, 32'(rsp_context), 32'(ex));
        chk({nm, ".multi"}, 32'(rsp_multi), 32'(em));
        h_val = rsp_value;
        cmd_op = 3'd1;
        cmd_valid = (stall > 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({nm, ".hold_v"}, 32'(rsp_valid), 32'd1);
            chk({nm, ".hold_val"}, 32'(rsp_value), 32'(h_val));
            chk({nm, ".hold_rdy"}, 32'(cmd_ready), 32'd0);
            chk({nm, ".hold_sel"}, 32'(cell_selector), 32'd8);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({nm, ".done_v"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".done_rdy"}, 32'(cmd_ready), 32'd1);
    endtask

    logic [N*8-1:0] rv, cx;
    logic [N-1:0]   rb;
    logic [2:0]     rop;

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 3'd1; cmd_array = 8'd0; cmd_index = 8'd0; cmd_value = 8'd0;
        rsp_ready = 1'b0;
        cell_bool = '0; cell_result_value = '0; cell_context = '0;
        repeat (3) tick();
        reset = 1'b1;
        cmd_valid = 1'b0;
        chk("rst.sel", 32'(cell_selector), 32'd8);
        chk("rst.ready", 32'(cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.hit", 32'(rsp_hit), 32'd0);
        chk("rst.value", 32'(rsp_value), 32'd0);
        chk("rst.multi", 32'(rsp_multi), 32'd0);
        chk("rst.meta", 32'(cell_metadata), 32'd0);
        chk("rst.ismeta", 32'(cell_isMetadata), 32'd0);
        chk("rst.idx", 32'(cell_inserted_index), 32'd0);
        tick();
        chk("rst.idle", 32'(cell_selector), 32'd8);

        rv = '0; cx = '0;
        for (int i = 0; i < N; i++) begin
            rv[i*8 +: 8] = 8'(8'h10 + i);
            cx[i*8 +: 8] = 8'(8'hC0 + i);
        end
        rv[2*8 +: 8] = 8'h2A;
        run_cmd("lookup", 3'd1, 8'd3, 8'd5, 8'd0, 8'b0010_0100, rv, cx, 0);
        run_cmd("ins_hit", 3'd0, 8'd9, 8'd4, 8'h77, 8'b0100_1000, rv, cx, 0);
        run_cmd("ins_full", 3'd0, 8'd9, 8'd4, 8'h77, 8'b0000_0000, rv, cx, 0);
        run_cmd("bp", 3'd3, 8'd1, 8'd2, 8'd0, 8'b1000_0000, rv, cx, 5);
        run_cmd("multi", 3'd2, 8'd7, 8'd1, 8'd0, 8'b0001_0001, rv, cx, 0);
        run_cmd("nohit", 3'd1, 8'd7, 8'd1, 8'd0, 8'b0000_0000, rv, cx, 0);
        run_cmd("rsvd", 3'd6, 8'd7, 8'd1, 8'd0, 8'b1111_1111, rv, cx, 2);

        // Reset while the INSERT write selector is on the bus.
        cell_bool = 8'b0000_0010;
        cmd_op = 3'd0; cmd_array = 8'd1; cmd_index = 8'd2; cmd_value = 8'd3;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid.write_sel", 32'(cell_selector), 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid.sel", 32'(cell_selector), 32'd8);
        chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid.ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid.no_rsp", 32'(rsp_valid), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                rv[i*8 +: 8] = 8'($urandom);
                cx[i*8 +: 8] = 8'($urandom);
            end
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = '1;
                default: rb = N'($urandom);
            endcase
            rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                              : 3'($urandom_range(0, 3));
            run_cmd("rand", rop, 8'($urandom), 8'($urandom), 8'($urandom),
                    rb, rv, cx, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
